// File: rtl/shift_op_sequencer.sv
// Opcode sequencer for the external 8-bit barrel shifter: queues 3-bit opcodes,
// replays them through the shifter one per cycle, and returns the byte via valid/ready.
module shift_op_sequencer #(
  parameter int OP_DEPTH = 8,
  parameter int PTR_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  output logic             op_ready,
  input  logic             start,
  input  logic [7:0]       data_in,
  output logic             busy,
  output logic [PTR_W:0]   op_count,
  output logic [2:0]       sh_s,
  output logic [7:0]       sh_a,
  input  logic [7:0]       sh_y,
  output logic             res_valid,
  output logic [7:0]       res_data,
  input  logic             res_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(OP_DEPTH);
  localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W + 1)'(1);

  logic [1:0]       state;
  logic [2:0]       fifo_mem [OP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_inc;
  logic [7:0]       acc;
  logic             push;
  logic             pop;

  assign op_ready  = (state == S_IDLE) && (count < FULL_COUNT);
  assign push      = op_valid && op_ready;
  assign pop       = (state == S_RUN);
  // Count including a push on this edge, so an op pushed alongside start joins the program.
  assign count_inc = count + {{PTR_W{1'b0}}, push};

  // NOTE: the opcode storage is not reset; the pointers and count define which
  // entries are live, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= op_code;
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      acc    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_inc - {{PTR_W{1'b0}}, pop};

      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= data_in;
            state <= (count_inc != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          acc <= sh_y;
          if (count == ONE_COUNT) state <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // acc is frozen in DONE, which keeps res_data stable under backpressure.
  assign busy      = (state != S_IDLE);
  assign op_count  = count;
  assign sh_s      = (state == S_RUN) ? fifo_mem[rd_ptr] : 3'd0;
  assign sh_a      = acc;
  assign res_valid = (state == S_DONE);
  assign res_data  = acc;

endmodule
